// File: rtl/audio_pkg.sv
// Shared audio link definitions: PWM period, sample width and decoder state type.
package audio_pkg;

  localparam int unsigned PWM_PERIOD = 256;
  localparam int unsigned SAMPLE_W   = 8;
  localparam int unsigned SAMPLE_MAX = (1 << SAMPLE_W) - 1;

  typedef enum logic {
    IDLE,
    TRACK
  } dec_state_e;

  // A full-high window counts PERIOD cycles, one more than a sample can hold.
  function automatic logic [SAMPLE_W-1:0] sat_sample(input logic [31:0] count);
    return (count > SAMPLE_MAX) ? '1 : count[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/audio_pwm_decoder_if.sv
// PWM receive link: the PWM stream in, recovered samples and lock status out.
interface audio_pwm_decoder_if;
  import audio_pkg::*;

  logic                pwm_in;
  logic [SAMPLE_W-1:0] sample;
  logic                sample_valid;
  logic                locked;
  logic                resync_err;

  modport master (
    output pwm_in,
    input  sample,
    input  sample_valid,
    input  locked,
    input  resync_err
  );

  modport slave (
    input  pwm_in,
    output sample,
    output sample_valid,
    output locked,
    output resync_err
  );

endinterface

// File: rtl/pwm_sync.sv
// Reset-to-0 multi-flop synchronizer for a single asynchronous input.
module pwm_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/audio_pwm_decoder.sv
// Recovers one sample per PWM period by counting high cycles in a window
// aligned to the rising edge at each period start.
module audio_pwm_decoder
  import audio_pkg::*;
#(
  parameter int unsigned PERIOD      = PWM_PERIOD,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  audio_pwm_decoder_if.slave  bus
);

  localparam int unsigned WCNT_W = $clog2(PERIOD);
  localparam int unsigned HCNT_W = WCNT_W + 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(PERIOD - 1);

  logic                s;
  logic                rise;
  logic [HCNT_W-1:0]   hsum;

  dec_state_e          state_q,  state_d;
  logic                s_prev_q, s_prev_d;
  logic [WCNT_W-1:0]   wcnt_q,   wcnt_d;
  logic [HCNT_W-1:0]   hcnt_q,   hcnt_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                valid_q,  valid_d;
  logic                locked_q, locked_d;
  logic                err_q,    err_d;

  pwm_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (bus.pwm_in),
    .q     (s)
  );

  assign rise = s & ~s_prev_q;
  assign hsum = hcnt_q + HCNT_W'(s);

  always_comb begin
    state_d  = state_q;
    s_prev_d = s;
    wcnt_d   = wcnt_q;
    hcnt_d   = hcnt_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = TRACK;
          wcnt_d  = WCNT_W'(1);
          hcnt_d  = HCNT_W'(1);
        end
      end
      TRACK: begin
        wcnt_d = wcnt_q + WCNT_W'(1);
        hcnt_d = hsum;
        if (wcnt_q == WCNT_LAST) begin
          sample_d = sat_sample(32'(hsum));
          valid_d  = 1'b1;
          locked_d = 1'b1;
          wcnt_d   = '0;
          hcnt_d   = '0;
        end
        // Any rise off window start restarts the window; when it lands on the
        // last cycle the completed sample above is still emitted.
        if (rise && (wcnt_q != '0)) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          wcnt_d   = WCNT_W'(1);
          hcnt_d   = HCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      s_prev_q <= 1'b0;
      wcnt_q   <= '0;
      hcnt_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_prev_q <= s_prev_d;
      wcnt_q   <= wcnt_d;
      hcnt_q   <= hcnt_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.locked       = locked_q;
  assign bus.resync_err   = err_q;

endmodule

// File: tb/tb_audio_pwm_decoder.sv
// Drives PWM periods of random width into the decoder and scoreboards the
// recovered samples, their spacing, lock latency and resync pulses.
module tb_audio_pwm_decoder;

  localparam int PER     = 256;
  localparam int SYNC    = 2;
  localparam int LAT     = SYNC + PER;  // pwm rise assignment edge to sample_valid edge

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  int   total = 0;
  int   bad   = 0;
  logic [7:0] exp_q[$];
  int   lock_cyc     = -1;
  int   last_cyc     = -1;
  bit   skip_spacing = 1'b0;
  int   resync_seen  = 0;
  int   resync_exp   = 0;

  audio_pwm_decoder_if bus ();

  audio_pwm_decoder #(
    .PERIOD      (PER),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        last_cyc     = -1;
        skip_spacing = 1'b0;
      end else begin
        if (bus.sample_valid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: got sample %0d, expected no sample_valid (cycle %0d)",
                     bus.sample, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("sample", int'(bus.sample), int'(e));
          end
          if (!bus.resync_err) chk("locked_at_valid", int'(bus.locked), 1);
          if (last_cyc >= 0 && !skip_spacing) chk("valid_spacing", cyc - last_cyc, PER);
          if (lock_cyc >= 0) begin
            chk("lock_latency", cyc - lock_cyc, LAT);
            lock_cyc = -1;
          end
          last_cyc     = cyc;
          skip_spacing = 1'b0;
        end
        if (bus.resync_err) begin
          resync_seen++;
          if (!bus.sample_valid) chk("locked_after_resync", int'(bus.locked), 0);
          skip_spacing = 1'b1;
        end
      end
    end
  endtask

  // One generator period: high for `hi` cycles out of `len`. Called and
  // returns #1 after a rising edge.
  task automatic gen(input int hi, input int len, input bit push, input int expv, input bit mark);
    if (push) exp_q.push_back(8'(expv));
    for (int i = 0; i < len; i++) begin
      bus.pwm_in = (i < hi);
      if (i == 0 && mark) lock_cyc = cyc;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_sample"}, int'(bus.sample), 0);
    chk({tag, "_valid"},  int'(bus.sample_valid), 0);
    chk({tag, "_locked"}, int'(bus.locked), 0);
    chk({tag, "_resync"}, int'(bus.resync_err), 0);
  endtask

  initial begin
    int d;
    int sweep [4] = '{0, 1, 254, 255};

    reset      = 1'b0;
    bus.pwm_in = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    reset = 1'b1;
    repeat (50) begin
      @(posedge clk);
      #1;
    end

    // steady mid-scale
    gen(128, PER, 1'b1, 128, 1'b1);
    repeat (5) gen(128, PER, 1'b1, 128, 1'b0);

    // boundary widths
    foreach (sweep[k]) gen(sweep[k], PER, 1'b1, sweep[k], 1'b0);

    repeat (12) begin
      d = int'($urandom_range(0, 255));
      gen(d, PER, 1'b1, d, 1'b0);
    end

    // generator skips 37 cycles: partial window is dropped
    d = int'($urandom_range(1, 200));
    gen(d, PER - 37, 1'b0, 0, 1'b0);
    resync_exp++;
    d = int'($urandom_range(1, 255));
    gen(d, PER, 1'b1, d, 1'b1);
    repeat (2) begin
      d = int'($urandom_range(0, 255));
      gen(d, PER, 1'b1, d, 1'b0);
    end

    // next rise lands on the window's last cycle, which counts as high
    d = int'($urandom_range(0, 200));
    gen(d, PER - 1, 1'b1, d + 1, 1'b0);
    resync_exp++;
    d = int'($urandom_range(1, 255));
    gen(d, PER, 1'b1, d, 1'b0);
    d = int'($urandom_range(0, 255));
    gen(d, PER, 1'b1, d, 1'b0);

    // reset in the middle of a window (wcnt = 100)
    for (int i = 0; i < 102; i++) begin
      bus.pwm_in = (i < 200);
      @(posedge clk);
      #1;
    end
    chk("queue_drained_before_reset", exp_q.size(), 0);
    chk("locked_before_reset", int'(bus.locked), 1);
    chk("sample_before_reset", int'(bus.sample), d);
    reset = 1'b0;
    #2;
    check_cleared("midreset");
    exp_q.delete();
    bus.pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (300) begin
      @(posedge clk);
      #1;
    end

    // pwm tied high from reset release: one rise, then saturated samples
    reset      = 1'b0;
    bus.pwm_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b1;
    lock_cyc = cyc;
    repeat (4) exp_q.push_back(8'd255);

    for (int n = 0; n < 2000 && exp_q.size() != 0; n++) @(posedge clk);
    chk("drain_timeout_pending", exp_q.size(), 0);
    #1;
    chk("resync_count", resync_seen, resync_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
